mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage load/store initiator for the pipelined MIPS core. It takes the EXE/MEM pipeline register outputs (address, store data, MemRead/MemWrite, access size, signedness) and runs a req/ack transaction to the byte-addressed, big-endian data memory. It generates byte-lane enables and lane-replicated store data, extracts and extends load data, and stalls the pipeline until the access completes. It also flags misaligned accesses and memory timeouts.

## Interface
- ADDR_W, 10, data memory byte-address width (1 KB space)
- ACK_TIMEOUT, 16, maximum BUSY cycles to wait for mem_ack before abort (≥1)

- clk  in  1  pipeline clock, all state on posedge
- rst_n  in  1  reset, asynchronous, active-low
- EXE_MEM_Result  in  32  effective byte address; bits [ADDR_W-1:0] used
- EXE_MEM_Rt  in  32  store data
- MemRead  in  1  load request from EXE/MEM
- MemWrite  in  1  store request from EXE/MEM
- MemSize  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- MemSigned  in  1  1 = sign-extend loads, 0 = zero-extend
- mem_req  out  1  request valid to memory
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables; be[3] = byte at offset 0 (bits 31:24)
- mem_rdata  in  32  read word, big-endian
- mem_ack  in  1  completion; sampled only in BUSY
- MEM_Result  out  32  formatted load data
- mem_stall  out  1  hold IF..EXE/MEM registers
- mem_misaligned  out  1  one-cycle error pulse
- mem_timeout  out  1  one-cycle error pulse

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, no MemRead/MemWrite: stay in IDLE, stall 0.
- IDLE with an op:
  - Aligned → latch addr/we/wdata/be/size/signed, go to BUSY.
  - Misaligned (half with addr[0]=1; word with addr[1:0]≠0) → no request, go to DONE with mem_misaligned=1.
- MemRead and MemWrite both high: treated as a write.
- Offset k = addr[1:0].
  - Byte: be = 4'b1000 >> k; wdata = {4{Rt[7:0]}}.
  - Half: be = 1100 (k=0) or 0011 (k=2); wdata = {2{Rt[15:0]}}.
  - Word: be = 1111; wdata = Rt.
- Load extraction:
  - Byte = rdata[31-8k -: 8].
  - Half = rdata[31-8k -: 16].
  - The selected field is extended per MemSigned to 32 bits.
- BUSY:
  - mem_req=1 with latched fields, all stable.
  - On mem_ack: capture the load into MEM_Result (stores leave it unchanged), go to DONE.
  - On timeout: drop mem_req, go to DONE with mem_timeout=1, MEM_Result unchanged.
- DONE: exactly one cycle, stall 0, inputs ignored (they still hold the retiring op), then IDLE.
- mem_stall = (IDLE & (MemRead|MemWrite)) | BUSY.
- Misaligned accesses also stall for their detect cycle.
- mem_ack in IDLE or DONE is ignored.

## Timing
- Reset (async assert, sync release): state IDLE; mem_req, mem_we, mem_addr, mem_wdata, mem_be, MEM_Result, mem_misaligned and mem_timeout all 0; timeout counter 0.
- Reset mid-BUSY drops mem_req immediately and leaves no pending transaction.
- mem_req, mem_we, mem_addr, mem_wdata and mem_be are registered, valid from the first BUSY cycle.
- Minimum load (ack in first BUSY cycle):
  - Cycle 0: IDLE detect, stall=1.
  - Cycle 1: BUSY, req=1, stall=1.
  - Cycle 2: DONE, MEM_Result valid, stall=0.
- Each extra BUSY cycle before ack adds one cycle of latency.
- The counter increments in each BUSY cycle without ack. If the ACK_TIMEOUT-th BUSY cycle ends with no ack → DONE with timeout.
- Ack arriving in that same final cycle takes priority over timeout.
- Error pulses are high only in the DONE cycle.
- Back-to-back ops: the next op is detected in the IDLE cycle after DONE, so there is no duplicate issue.
- MEM_Result holds its value until the next completed load.

## Test plan
- lw at 0x01C, mem_rdata=0x0000_0020, ack after 2 BUSY cycles → be=1111, mem_addr=0x01C, stall high 3 cycles, MEM_Result=0x0000_0020 in DONE.
- lb signed at 0x005, rdata=0x1280_3456 → be=0100, MEM_Result=0xFFFF_FF80; same access unsigned → 0x0000_0080.
- sh at 0x00A, Rt=0xDEAD_BEEF → mem_we=1, be=0011, wdata=0xBEEF_BEEF, MEM_Result unchanged.
- lw at 0x006 → no mem_req, mem_misaligned=1 for 1 cycle, stall 1 cycle only.
- lw with ack never asserted → mem_req high exactly 16 cycles, then mem_timeout pulse, back to IDLE; separately, ack in the 16th cycle → normal completion, no timeout.
- sw with rst_n low in the 2nd BUSY cycle → mem_req=0 and all outputs 0 immediately; after release with no op → IDLE, stall 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator for the pipelined MIPS core.
// Runs one req/ack transaction per load/store against a byte-addressed,
// big-endian data memory, builds byte-lane enables and replicated store data,
// extracts and extends load data, and stalls the pipeline while busy.
// Misaligned accesses and unanswered requests end in one-cycle error pulses.
module mem_access_unit #(
  parameter int ADDR_W      = 10,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       EXE_MEM_Result,
  input  logic [31:0]       EXE_MEM_Rt,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemSize,
  input  logic              MemSigned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       MEM_Result,
  output logic              mem_stall,
  output logic              mem_misaligned,
  output logic              mem_timeout
);

  // The counter only has to reach ACK_TIMEOUT-1, the index of the last BUSY cycle.
  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic              signed_q;
  logic [31:0]       result_q;
  logic              misaligned_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              opValid;
  logic [1:0]        offset;
  logic              misaligned;
  logic              lastBusy;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d;
  logic [31:0]       loadData;
  logic [7:0]        byteSel;
  logic [15:0]       halfSel;

  // Address bits above the memory window are deliberately ignored.
  logic unusedAddrBits;
  assign unusedAddrBits = ^EXE_MEM_Result[31:ADDR_W];

  assign opValid  = MemRead | MemWrite;
  assign offset   = EXE_MEM_Result[1:0];
  assign lastBusy = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  // Halfwords need an even address, words (size 10 or 11) a multiple of four.
  always_comb begin
    misaligned = 1'b0;
    if (MemSize == 2'b01) begin
      misaligned = offset[0];
    end else if (MemSize[1]) begin
      misaligned = (offset != 2'b00);
    end
  end

  // Byte enables and lane-replicated store data for the incoming op.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = EXE_MEM_Rt;
    case (MemSize)
      2'b00: begin
        be_d    = 4'b1000 >> offset;
        wdata_d = {4{EXE_MEM_Rt[7:0]}};
      end
      2'b01: begin
        be_d    = offset[1] ? 4'b0011 : 4'b1100;
        wdata_d = {2{EXE_MEM_Rt[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = EXE_MEM_Rt;
      end
    endcase
  end

  // Pick the addressed big-endian field from the read word and extend it.
  always_comb begin
    byteSel  = mem_rdata[31:24];
    halfSel  = mem_rdata[31:16];
    loadData = mem_rdata;
    case (off_q)
      2'd0:    byteSel = mem_rdata[31:24];
      2'd1:    byteSel = mem_rdata[23:16];
      2'd2:    byteSel = mem_rdata[15:8];
      default: byteSel = mem_rdata[7:0];
    endcase
    halfSel = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (size_q)
      2'b00:   loadData = {{24{signed_q & byteSel[7]}}, byteSel};
      2'b01:   loadData = {{16{signed_q & halfSel[15]}}, halfSel};
      default: loadData = mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: an ack in the final BUSY cycle wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (opValid) begin
          state_d = misaligned ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (mem_ack || lastBusy) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stall while an op waits in IDLE (including its misaligned detect cycle) or is in flight.
  always_comb begin
    mem_stall = ((state_q == IDLE) && opValid) || (state_q == BUSY);
  end

  // Transaction registers: latch the request on issue, retire it on ack or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      size_q       <= '0;
      off_q        <= '0;
      signed_q     <= 1'b0;
      result_q     <= '0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (opValid && misaligned) begin
            misaligned_q <= 1'b1;
          end else if (opValid) begin
            req_q    <= 1'b1;
            we_q     <= MemWrite;
            addr_q   <= {EXE_MEM_Result[ADDR_W-1:2], 2'b00};
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            size_q   <= MemSize;
            off_q    <= offset;
            signed_q <= MemSigned;
            cnt_q    <= '0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            req_q <= 1'b0;
            cnt_q <= '0;
            if (!we_q) begin
              result_q <= loadData;
            end
          end else if (lastBusy) begin
            req_q     <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_req        = req_q;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_be         = be_q;
  assign MEM_Result     = result_q;
  assign mem_misaligned = misaligned_q;
  assign mem_timeout    = timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: drives loads/stores through mem_access_unit and checks
// lanes, data, stall/latency, error pulses and load formatting against a
// transaction-level reference model.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] EXE_MEM_Result;
  logic [31:0] EXE_MEM_Rt;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemSize;
  logic        MemSigned;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] MEM_Result;
  logic        mem_stall;
  logic        mem_misaligned;
  logic        mem_timeout;

  int checks = 0;
  int failures = 0;

  // Observations gathered by the transaction driver.
  int          obsStall;
  int          obsReq;
  bit          obsUnstable;
  bit          obsDone;
  logic        obsDoneStall;
  logic        obsMis;
  logic        obsTo;
  logic [31:0] obsResult;
  logic [3:0]  obsBe;
  logic [9:0]  obsAddr;
  logic [31:0] obsWdata;
  logic        obsWe;
  logic        idleReq;
  logic        idleReq2;
  logic        idleStall;
  logic        idleMis;
  logic        idleTo;

  logic [31:0] modelResult;

  mem_access_unit #(.ADDR_W(10), .ACK_TIMEOUT(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .EXE_MEM_Result (EXE_MEM_Result),
    .EXE_MEM_Rt     (EXE_MEM_Rt),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .MemSize        (MemSize),
    .MemSigned      (MemSigned),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_be         (mem_be),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .MEM_Result     (MEM_Result),
    .mem_stall      (mem_stall),
    .mem_misaligned (mem_misaligned),
    .mem_timeout    (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: access width in bytes, size 11 behaves as a word.
  function automatic int nBytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit modelMis(input logic [1:0] size, input logic [31:0] addr);
    return (addr % nBytes(size)) != 0;
  endfunction

  // Big-endian: byte at offset k sits in lane 3-k; a field of n bytes covers lanes 3-k down to 4-k-n.
  function automatic logic [3:0] modelBe(input logic [1:0] size, input logic [31:0] addr);
    int n = nBytes(size);
    int k = int'(addr % 4);
    return 4'(((1 << n) - 1) << (4 - k - n));
  endfunction

  function automatic logic [31:0] modelWdata(input logic [1:0] size, input logic [31:0] rt);
    int n = nBytes(size);
    logic [63:0] pat = 64'(rt) & ((64'd1 << (8 * n)) - 1);
    logic [63:0] acc = 0;
    for (int i = 0; i < 4 / n; i++) acc = (acc << (8 * n)) | pat;
    return acc[31:0];
  endfunction

  function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic sgn,
                                            input logic [31:0] addr, input logic [31:0] rdata);
    int n = nBytes(size);
    int k = int'(addr % 4);
    logic [63:0] mask = (64'd1 << (8 * n)) - 1;
    logic [63:0] val = (64'(rdata) >> (8 * (4 - k - n))) & mask;
    if (sgn && n < 4 && val[8 * n - 1]) val = val | ~mask;
    return val[31:0];
  endfunction

  // Drive one op from the IDLE cycle through DONE, recording what the DUT did.
  // ackCycle is the 1-based BUSY cycle carrying mem_ack (0 = never).
  task automatic runOp(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] rt, input logic [1:0] size, input logic sgn,
                       input logic [31:0] rdata, input int ackCycle);
    @(negedge clk);
    MemWrite = wr; MemRead = rd; EXE_MEM_Result = addr; EXE_MEM_Rt = rt;
    MemSize = size; MemSigned = sgn; mem_rdata = rdata; mem_ack = 1'b0;
    #1;
    obsStall = mem_stall ? 1 : 0;
    obsReq = 0; obsUnstable = 0; obsDone = 0;
    obsDoneStall = 1'bx; obsMis = 1'bx; obsTo = 1'bx; obsResult = 'x;
    for (int c = 0; c < 40 && !obsDone; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        obsReq++;
        if (mem_stall) obsStall++;
        if (obsReq == 1) begin
          obsBe = mem_be; obsAddr = mem_addr; obsWdata = mem_wdata; obsWe = mem_we;
        end else if ({mem_be, mem_addr, mem_wdata, mem_we} !== {obsBe, obsAddr, obsWdata, obsWe}) begin
          obsUnstable = 1;
        end
        if (obsReq == ackCycle) mem_ack = 1'b1;
      end else begin
        obsDone = 1;
        obsDoneStall = mem_stall; obsMis = mem_misaligned; obsTo = mem_timeout; obsResult = MEM_Result;
        mem_ack = 1'b1;
      end
    end
  endtask

  // Retire the op in the IDLE cycle after DONE and sample the quiet state.
  task automatic goIdle();
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
    #1;
    idleReq = mem_req; idleStall = mem_stall; idleMis = mem_misaligned; idleTo = mem_timeout;
    @(negedge clk);
    idleReq2 = mem_req;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; MemRead = 0; MemWrite = 0; MemSize = 0; MemSigned = 0;
    EXE_MEM_Result = 0; EXE_MEM_Rt = 0; mem_rdata = 0; mem_ack = 0;
    #2;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, MEM_Result, mem_misaligned, mem_timeout, mem_stall} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got req=%b we=%b addr=%h wdata=%h be=%b res=%h mis=%b to=%b stall=%b expected all 0",
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, MEM_Result, mem_misaligned, mem_timeout, mem_stall);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    modelResult = 0;
    @(negedge clk);
    checks++;
    if (mem_stall !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release_idle got stall=%b req=%b expected 0 0", mem_stall, mem_req);
    end
  endtask

  task automatic test_load_word();
    runOp(1'b0, 1'b1, 32'h01C, 32'h0, 2'b10, 1'b0, 32'h0000_0020, 2);
    modelResult = 32'h0000_0020;
    checks++;
    if (obsBe !== 4'b1111 || obsAddr !== 10'h01C || obsWe !== 1'b0) begin
      failures++; $display("[TB] FAIL lw_lanes got be=%b addr=%h we=%b expected 1111 01c 0", obsBe, obsAddr, obsWe);
    end
    checks++;
    if (obsStall !== 3 || obsReq !== 2 || obsUnstable) begin
      failures++; $display("[TB] FAIL lw_latency got stall=%0d req=%0d unstable=%0d expected 3 2 0", obsStall, obsReq, obsUnstable);
    end
    checks++;
    if (!obsDone || obsResult !== 32'h0000_0020 || obsDoneStall !== 1'b0 || obsMis !== 1'b0 || obsTo !== 1'b0) begin
      failures++; $display("[TB] FAIL lw_done got done=%0d res=%h stall=%b mis=%b to=%b expected 1 00000020 0 0 0",
                           obsDone, obsResult, obsDoneStall, obsMis, obsTo);
    end
    goIdle();
    checks++;
    if (idleReq !== 1'b0 || idleReq2 !== 1'b0 || idleStall !== 1'b0 || MEM_Result !== modelResult) begin
      failures++; $display("[TB] FAIL lw_idle got req=%b/%b stall=%b res=%h expected 0/0 0 %h",
                           idleReq, idleReq2, idleStall, MEM_Result, modelResult);
    end
  endtask

  task automatic test_load_byte();
    runOp(1'b0, 1'b1, 32'h005, 32'h0, 2'b00, 1'b1, 32'h1280_3456, 1);
    modelResult = 32'hFFFF_FF80;
    checks++;
    if (obsBe !== 4'b0100 || obsAddr !== 10'h004 || obsStall !== 2 || obsResult !== 32'hFFFF_FF80) begin
      failures++; $display("[TB] FAIL lb_signed got be=%b addr=%h stall=%0d res=%h expected 0100 004 2 ffffff80",
                           obsBe, obsAddr, obsStall, obsResult);
    end
    goIdle();
    runOp(1'b0, 1'b1, 32'h005, 32'h0, 2'b00, 1'b0, 32'h1280_3456, 1);
    modelResult = 32'h0000_0080;
    checks++;
    if (obsBe !== 4'b0100 || obsResult !== 32'h0000_0080) begin
      failures++; $display("[TB] FAIL lbu got be=%b res=%h expected 0100 00000080", obsBe, obsResult);
    end
    goIdle();
  endtask

  task automatic test_store_half();
    // MemRead is also high: the op must still be a write.
    runOp(1'b1, 1'b1, 32'h00A, 32'hDEAD_BEEF, 2'b01, 1'b0, 32'hCAFE_F00D, 1);
    checks++;
    if (obsWe !== 1'b1 || obsBe !== 4'b0011 || obsWdata !== 32'hBEEF_BEEF || obsAddr !== 10'h008) begin
      failures++; $display("[TB] FAIL sh_lanes got we=%b be=%b wdata=%h addr=%h expected 1 0011 beefbeef 008",
                           obsWe, obsBe, obsWdata, obsAddr);
    end
    checks++;
    if (obsResult !== modelResult) begin
      failures++; $display("[TB] FAIL sh_result_kept got %h expected %h", obsResult, modelResult);
    end
    goIdle();
  endtask

  task automatic test_misaligned();
    runOp(1'b0, 1'b1, 32'h006, 32'h0, 2'b10, 1'b0, 32'h1111_1111, 1);
    checks++;
    if (obsReq !== 0 || obsStall !== 1 || obsMis !== 1'b1 || obsTo !== 1'b0 || obsDoneStall !== 1'b0) begin
      failures++; $display("[TB] FAIL lw_misaligned got req=%0d stall=%0d mis=%b to=%b dstall=%b expected 0 1 1 0 0",
                           obsReq, obsStall, obsMis, obsTo, obsDoneStall);
    end
    goIdle();
    checks++;
    if (idleMis !== 1'b0 || idleReq !== 1'b0 || MEM_Result !== modelResult) begin
      failures++; $display("[TB] FAIL misaligned_pulse_end got mis=%b req=%b res=%h expected 0 0 %h",
                           idleMis, idleReq, MEM_Result, modelResult);
    end
  endtask

  task automatic test_timeout();
    runOp(1'b0, 1'b1, 32'h100, 32'h0, 2'b10, 1'b0, 32'h7777_7777, 0);
    checks++;
    if (!obsDone || obsReq !== 16 || obsStall !== 17 || obsTo !== 1'b1 || obsResult !== modelResult) begin
      failures++; $display("[TB] FAIL timeout got done=%0d req=%0d stall=%0d to=%b res=%h expected 1 16 17 1 %h",
                           obsDone, obsReq, obsStall, obsTo, obsResult, modelResult);
    end
    goIdle();
    checks++;
    if (idleTo !== 1'b0 || idleReq !== 1'b0 || idleStall !== 1'b0) begin
      failures++; $display("[TB] FAIL timeout_pulse_end got to=%b req=%b stall=%b expected 0 0 0", idleTo, idleReq, idleStall);
    end
  endtask

  task automatic test_ack_last_cycle();
    runOp(1'b0, 1'b1, 32'h104, 32'h0, 2'b10, 1'b0, 32'h3C3C_5A5A, 16);
    modelResult = 32'h3C3C_5A5A;
    checks++;
    if (obsReq !== 16 || obsTo !== 1'b0 || obsResult !== 32'h3C3C_5A5A) begin
      failures++; $display("[TB] FAIL ack_last_cycle got req=%0d to=%b res=%h expected 16 0 3c3c5a5a", obsReq, obsTo, obsResult);
    end
    goIdle();
  endtask

  task automatic test_back_to_back();
    runOp(1'b0, 1'b1, 32'h023, 32'h0, 2'b00, 1'b1, 32'h0102_0304, 1);
    modelResult = 32'h0000_0004;
    checks++;
    if (obsReq !== 1 || obsResult !== 32'h0000_0004) begin
      failures++; $display("[TB] FAIL b2b_first got req=%0d res=%h expected 1 00000004", obsReq, obsResult);
    end
    runOp(1'b1, 1'b0, 32'h3F0, 32'h89AB_CDEF, 2'b11, 1'b0, 32'h0, 3);
    checks++;
    if (obsReq !== 3 || obsStall !== 4 || obsWe !== 1'b1 || obsAddr !== 10'h3F0 || obsWdata !== 32'h89AB_CDEF || obsBe !== 4'b1111) begin
      failures++; $display("[TB] FAIL b2b_second got req=%0d stall=%0d we=%b addr=%h wdata=%h be=%b expected 3 4 1 3f0 89abcdef 1111",
                           obsReq, obsStall, obsWe, obsAddr, obsWdata, obsBe);
    end
    goIdle();
    checks++;
    if (idleReq !== 1'b0 || idleReq2 !== 1'b0 || MEM_Result !== modelResult) begin
      failures++; $display("[TB] FAIL b2b_no_duplicate got req=%b/%b res=%h expected 0/0 %h", idleReq, idleReq2, MEM_Result, modelResult);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a = $urandom;
      logic [31:0] rt = $urandom;
      logic [31:0] rdata = $urandom;
      logic [1:0]  size = 2'($urandom_range(0, 3));
      logic        wr = 1'($urandom_range(0, 1));
      logic        rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      logic        sgn = 1'($urandom_range(0, 1));
      int          ack = $urandom_range(0, 17);
      bit          expTo = (ack < 1 || ack > 16);
      int          expReq = expTo ? 16 : ack;
      runOp(wr, rd, a, rt, size, sgn, rdata, ack);
      if (modelMis(size, a)) begin
        checks++;
        if (obsReq !== 0 || obsStall !== 1 || obsMis !== 1'b1 || obsTo !== 1'b0) begin
          failures++; $display("[TB] FAIL rand_misaligned[%0d] got req=%0d stall=%0d mis=%b to=%b expected 0 1 1 0",
                               i, obsReq, obsStall, obsMis, obsTo);
        end
      end else begin
        if (!wr && !expTo) modelResult = modelLoad(size, sgn, a, rdata);
        checks++;
        if (obsBe !== modelBe(size, a) || obsAddr !== {a[9:2], 2'b00} || obsWdata !== modelWdata(size, rt) || obsWe !== wr) begin
          failures++; $display("[TB] FAIL rand_request[%0d] got be=%b addr=%h wdata=%h we=%b expected %b %h %h %b",
                               i, obsBe, obsAddr, obsWdata, obsWe, modelBe(size, a), {a[9:2], 2'b00}, modelWdata(size, rt), wr);
        end
        checks++;
        if (obsReq !== expReq || obsStall !== expReq + 1 || obsTo !== expTo || obsMis !== 1'b0 || obsUnstable) begin
          failures++; $display("[TB] FAIL rand_timing[%0d] got req=%0d stall=%0d to=%b mis=%b unstable=%0d expected %0d %0d %b 0 0",
                               i, obsReq, obsStall, obsTo, obsMis, obsUnstable, expReq, expReq + 1, expTo);
        end
      end
      checks++;
      if (obsResult !== modelResult) begin
        failures++; $display("[TB] FAIL rand_result[%0d] got %h expected %h", i, obsResult, modelResult);
      end
      goIdle();
    end
  endtask

  task automatic test_reset_mid_busy();
    int waitCnt = 0;
    @(negedge clk);
    MemWrite = 1'b1; MemRead = 1'b0; MemSize = 2'b10; EXE_MEM_Result = 32'h040; EXE_MEM_Rt = $urandom; mem_ack = 1'b0;
    while (mem_req !== 1'b1 && waitCnt < 5) begin
      @(negedge clk); waitCnt++;
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      failures++; $display("[TB] FAIL rst_busy_precond got req=%b expected 1", mem_req);
    end
    rst_n = 1'b0; MemWrite = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, MEM_Result, mem_misaligned, mem_timeout, mem_stall} !== '0) begin
      failures++; $display("[TB] FAIL rst_busy_outputs got req=%b we=%b addr=%h wdata=%h be=%b res=%h stall=%b expected all 0",
                           mem_req, mem_we, mem_addr, mem_wdata, mem_be, MEM_Result, mem_stall);
    end
    modelResult = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idleReq = mem_req; idleStall = mem_stall;
    @(negedge clk);
    checks++;
    if (idleReq !== 1'b0 || idleStall !== 1'b0 || mem_req !== 1'b0 || mem_stall !== 1'b0) begin
      failures++; $display("[TB] FAIL rst_busy_release got req=%b/%b stall=%b/%b expected 0 0", idleReq, mem_req, idleStall, mem_stall);
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_ack_last_cycle();
    test_back_to_back();
    test_random();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound the whole run so a stuck DUT still ends the simulation.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog got no completion expected finish before 300000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
